// File: rtl/conv_engine_arbiter_if.sv
// Handshake/bus bundle for conv_engine_arbiter.
//   req / req_done / req_err : requester-side job handshake (one bit per requester)
//   grant_id / busy          : operand-mux select and job-in-progress flag
//   eng_*                    : convolution engine control and pixel stream
//   pix_*                    : forwarded pixel stream tagged with owner and raster index
// Modports: master = the arbiter, slave = requesters/engine side.
interface conv_engine_arbiter_if #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned HEIGHT    = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned K         = 2
);
  localparam int unsigned NPIX = (HEIGHT - K + 1) * (WIDTH - K + 1);
  localparam int unsigned IDW  = $clog2(N_REQ);
  localparam int unsigned IXW  = $clog2(NPIX + 1);

  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     req_done;
  logic [N_REQ-1:0]     req_err;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 eng_rst;
  logic                 eng_start;
  logic                 eng_done;
  logic                 eng_out_valid;
  logic [ACC_WIDTH-1:0] eng_out_pixel;
  logic                 pix_valid;
  logic [ACC_WIDTH-1:0] pix_data;
  logic [IDW-1:0]       pix_id;
  logic [IXW-1:0]       pix_idx;

  modport master (
    input  req, eng_done, eng_out_valid, eng_out_pixel,
    output req_done, req_err, grant_id, busy, eng_rst, eng_start,
           pix_valid, pix_data, pix_id, pix_idx
  );

  modport slave (
    output req, eng_done, eng_out_valid, eng_out_pixel,
    input  req_done, req_err, grant_id, busy, eng_rst, eng_start,
           pix_valid, pix_data, pix_id, pix_idx
  );
endinterface

// File: rtl/conv_engine_arbiter.sv
// Round-robin arbiter sharing one convolution engine between N_REQ requesters.
// Per job: CLEAR (engine reset pulse), LAUNCH (start pulse), RUN (forward tagged
// pixels, count them, watch for eng_done or timeout), RELEASE (req_done/req_err).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : conv_engine_arbiter_if.master (requests, engine control, pixel stream)
// All outputs are registered.
module conv_engine_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned HEIGHT    = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned K         = 2,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_engine_arbiter_if.master  bus
);
  localparam int unsigned OUT_H = HEIGHT - K + 1;
  localparam int unsigned OUT_W = WIDTH - K + 1;
  localparam int unsigned NPIX  = OUT_H * OUT_W;
  localparam int unsigned IDW   = $clog2(N_REQ);
  localparam int unsigned IXW   = $clog2(NPIX + 1);
  localparam int unsigned CNTW  = $clog2(NPIX + 2);
  localparam int unsigned TMOW  = $clog2(TIMEOUT + 1);

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NPIX);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(NPIX + 1);
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  LAST_RST = IDW'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [TMOW-1:0]      tmo_q, tmo_d;
  logic                 eng_rst_q, eng_rst_d;
  logic                 eng_start_q, eng_start_d;
  logic                 busy_q, busy_d;
  logic [N_REQ-1:0]     req_done_q, req_done_d;
  logic [N_REQ-1:0]     req_err_q, req_err_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [ACC_WIDTH-1:0] pix_data_q, pix_data_d;
  logic [IDW-1:0]       pix_id_q, pix_id_d;
  logic [IXW-1:0]       pix_idx_q, pix_idx_d;

  logic                 pick_found;
  logic [IDW-1:0]       pick;
  logic [IDW-1:0]       cand;
  logic [CNTW-1:0]      cnt_inc;
  logic [CNTW-1:0]      cnt_now;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    eng_rst_d   = 1'b0;
    eng_start_d = 1'b0;
    req_done_d  = '0;
    req_err_d   = '0;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    pix_id_d    = pix_id_q;
    pix_idx_d   = pix_idx_q;
    pick_found  = 1'b0;
    pick        = '0;
    cand        = '0;

    // Round-robin search starting just after the last granted requester.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDW'((32'(last_q) + i) % N_REQ);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end

    cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    cnt_now = bus.eng_out_valid ? cnt_inc : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d   = S_CLEAR;
          grant_d   = pick;
          last_d    = pick;
          eng_rst_d = 1'b1;
        end
      end
      S_CLEAR: begin
        // Counters are zeroed as LAUNCH is entered, so tmo_q counts cycles
        // since LAUNCH and equals TIMEOUT-1 in the abort RELEASE cycle.
        state_d     = S_LAUNCH;
        eng_start_d = 1'b1;
        cnt_d       = '0;
        tmo_d       = '0;
      end
      S_LAUNCH: begin
        state_d = S_RUN;
        tmo_d   = tmo_q + 1'b1;
      end
      S_RUN: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.eng_out_valid) begin
          pix_valid_d = 1'b1;
          pix_data_d  = bus.eng_out_pixel;
          pix_id_d    = grant_q;
          pix_idx_d   = IXW'(cnt_q);
          cnt_d       = cnt_inc;
        end
        if (bus.eng_done) begin
          state_d             = S_RELEASE;
          req_done_d[grant_q] = 1'b1;
          req_err_d[grant_q]  = (cnt_now != CNT_FULL);
        end else if (tmo_d == TMO_LAST) begin
          state_d             = S_RELEASE;
          eng_rst_d           = 1'b1;
          req_done_d[grant_q] = 1'b1;
          req_err_d[grant_q]  = 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= LAST_RST;
      cnt_q       <= '0;
      tmo_q       <= '0;
      eng_rst_q   <= 1'b1;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      req_done_q  <= '0;
      req_err_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_id_q    <= '0;
      pix_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      eng_rst_q   <= eng_rst_d;
      eng_start_q <= eng_start_d;
      busy_q      <= busy_d;
      req_done_q  <= req_done_d;
      req_err_q   <= req_err_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_id_q    <= pix_id_d;
      pix_idx_q   <= pix_idx_d;
    end
  end

  assign bus.req_done  = req_done_q;
  assign bus.req_err   = req_err_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;
  assign bus.eng_rst   = eng_rst_q;
  assign bus.eng_start = eng_start_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.pix_id    = pix_id_q;
  assign bus.pix_idx   = pix_idx_q;
endmodule

// File: tb/tb_conv_engine_arbiter.sv
// Testbench for conv_engine_arbiter: behavioural engine stub, pixel monitor,
// a table of job scenarios with hand-derived expectations, reset/stray-pixel
// sequences, and randomized jobs checked against a round-robin model.
module tb_conv_engine_arbiter;
  localparam int unsigned N_REQ     = 4;
  localparam int unsigned ACC_WIDTH = 32;
  localparam int unsigned HEIGHT    = 4;
  localparam int unsigned WIDTH     = 4;
  localparam int unsigned K         = 2;
  localparam int unsigned TIMEOUT   = 64;
  localparam int          NPIX      = (HEIGHT - K + 1) * (WIDTH - K + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_engine_arbiter_if #(.N_REQ(N_REQ), .ACC_WIDTH(ACC_WIDTH), .HEIGHT(HEIGHT),
                           .WIDTH(WIDTH), .K(K)) bus ();

  conv_engine_arbiter #(.N_REQ(N_REQ), .ACC_WIDTH(ACC_WIDTH), .HEIGHT(HEIGHT),
                        .WIDTH(WIDTH), .K(K), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // engine stub knobs and expected pixel stream
  int   e_npix    = 0;
  bit   e_done_en = 1'b1;
  bit   e_same    = 1'b0;
  int   e_gap     = 1;
  bit   stray_req = 1'b0;
  logic [ACC_WIDTH-1:0] exp_q[$];

  // monitor expectations
  int exp_grant = 0;
  int exp_idx   = 0;
  int pix_seen  = 0;
  int model_last = N_REQ - 1;

  typedef struct {
    logic [N_REQ-1:0] or_mask;
    int               npix;
    bit               done_en;
    bit               same;
    logic [N_REQ-1:0] mid;
    int               exp_g;
    bit               exp_err;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic finish_now();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  endtask

  // Grant = lowest set index above the last grant, else the lowest set index.
  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] r);
    for (int j = 0; j < N_REQ; j++) if (r[j] && j > last) return j;
    for (int j = 0; j < N_REQ; j++) if (r[j]) return j;
    return -1;
  endfunction

  // Engine stub: on start, emits e_npix pixels every (e_gap+1) cycles, then
  // raises done (level) one cycle later, or with the last pixel if e_same.
  initial begin
    bit emitting;
    int left;
    int gapc;
    logic [ACC_WIDTH-1:0] px;
    emitting = 1'b0; left = 0; gapc = 0;
    bus.eng_done = 1'b0;
    bus.eng_out_valid = 1'b0;
    bus.eng_out_pixel = '0;
    forever begin
      @(negedge clk);
      bus.eng_out_valid = 1'b0;
      if (rst || bus.eng_rst) begin
        bus.eng_done = 1'b0;
        emitting = 1'b0;
      end
      if (stray_req) begin
        bus.eng_out_valid = 1'b1;
        bus.eng_out_pixel = 32'hDEAD_BEEF;
        stray_req = 1'b0;
      end else if (!rst && bus.eng_start) begin
        emitting = 1'b1;
        left = e_npix;
        gapc = 0;
      end else if (!rst && emitting) begin
        if (left > 0) begin
          if (gapc == 0) begin
            px = $urandom;
            bus.eng_out_valid = 1'b1;
            bus.eng_out_pixel = px;
            exp_q.push_back(px);
            left--;
            gapc = e_gap;
            if (left == 0 && e_same) begin
              emitting = 1'b0;
              bus.eng_done = e_done_en;
            end
          end else begin
            gapc--;
          end
        end else begin
          emitting = 1'b0;
          bus.eng_done = e_done_en;
        end
      end
    end
  end

  // Pixel monitor
  initial begin
    logic [ACC_WIDTH-1:0] d;
    forever begin
      @(negedge clk);
      if (bus.pix_valid) begin
        pix_seen++;
        if (exp_q.size() == 0) begin
          chk("pix_unexpected", 64'(bus.pix_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          d = exp_q.pop_front();
          chk("pix_data", 64'(bus.pix_data), 64'(d));
        end
        chk("pix_id", 64'(bus.pix_id), 64'(exp_grant));
        chk("pix_idx", 64'(bus.pix_idx), 64'(exp_idx));
        exp_idx++;
      end
    end
  end

  // One job from request to IDLE. Called at a negedge with the arbiter idle.
  task automatic run_job(input logic [N_REQ-1:0] or_mask, input int npix, input bit done_en,
                         input bit same, input logic [N_REQ-1:0] mid, input int exp_g,
                         input bit exp_err);
    int k;
    int launch;
    bus.req   = bus.req | or_mask;
    e_npix    = npix;
    e_done_en = done_en;
    e_same    = same;
    exp_grant = exp_g;
    exp_idx   = 0;
    pix_seen  = 0;
    k = 0;
    while (!bus.busy && k < 10) begin @(negedge clk); k++; end
    if (!bus.busy) begin chk("busy_rise", 64'(bus.busy), 64'd1); finish_now(); end
    chk("grant", 64'(bus.grant_id), 64'(exp_g));
    chk("clear_pulse", 64'({bus.eng_rst, bus.eng_start}), 64'b10);
    @(negedge clk);
    launch = cyc;
    chk("launch_pulse", 64'({bus.eng_rst, bus.eng_start}), 64'b01);
    bus.req = bus.req ^ mid;
    k = 0;
    while (bus.req_done == '0 && k < int'(TIMEOUT) + 10) begin @(negedge clk); k++; end
    if (bus.req_done == '0) begin chk("done_seen", 64'(bus.req_done), 64'(1) << exp_g); finish_now(); end
    chk("req_done", 64'(bus.req_done), 64'(1) << exp_g);
    chk("req_err", 64'(bus.req_err), exp_err ? (64'(1) << exp_g) : 64'd0);
    chk("grant_hold", 64'(bus.grant_id), 64'(exp_g));
    chk("release_eng_rst", 64'(bus.eng_rst), done_en ? 64'd0 : 64'd1);
    if (!done_en) chk("timeout_cycle", 64'(cyc - launch), 64'(TIMEOUT - 1));
    bus.req[exp_g] = 1'b0;
    model_last = exp_g;
    @(negedge clk);
    chk("busy_low", 64'(bus.busy), 64'd0);
    chk("pix_count", 64'(pix_seen), 64'(npix));
    chk("pix_leftover", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      64'(bus.busy),      64'd0);
    chk({tag, "_eng_rst"},   64'(bus.eng_rst),   64'd1);
    chk({tag, "_eng_start"}, 64'(bus.eng_start), 64'd0);
    chk({tag, "_req_done"},  64'(bus.req_done),  64'd0);
    chk({tag, "_req_err"},   64'(bus.req_err),   64'd0);
    chk({tag, "_pix_valid"}, 64'(bus.pix_valid), 64'd0);
    chk({tag, "_pix_data"},  64'(bus.pix_data),  64'd0);
    chk({tag, "_pix_idx"},   64'(bus.pix_idx),   64'd0);
    chk({tag, "_grant_id"},  64'(bus.grant_id),  64'd0);
  endtask

  initial begin
    logic [N_REQ-1:0] orm;
    logic [N_REQ-1:0] mx;
    int np;
    int sel;
    bit de;
    bit sm;
    int g;
    int k;

    //            or_mask  npix       done same mid     grant err
    tbl[0]  = '{4'b0001, NPIX,      1'b1, 1'b0, 4'b0000, 0, 1'b0};
    tbl[1]  = '{4'b1111, NPIX,      1'b1, 1'b0, 4'b0000, 1, 1'b0};
    tbl[2]  = '{4'b0000, NPIX,      1'b1, 1'b0, 4'b0000, 2, 1'b0};
    tbl[3]  = '{4'b0000, NPIX,      1'b1, 1'b0, 4'b0000, 3, 1'b0};
    tbl[4]  = '{4'b0000, NPIX,      1'b1, 1'b0, 4'b0000, 0, 1'b0};
    tbl[5]  = '{4'b1111, NPIX,      1'b1, 1'b0, 4'b0000, 1, 1'b0};
    tbl[6]  = '{4'b0000, NPIX,      1'b1, 1'b0, 4'b0000, 2, 1'b0};
    tbl[7]  = '{4'b0000, NPIX,      1'b1, 1'b0, 4'b0000, 3, 1'b0};
    tbl[8]  = '{4'b0000, NPIX,      1'b1, 1'b0, 4'b0000, 0, 1'b0};
    tbl[9]  = '{4'b0100, NPIX,      1'b1, 1'b0, 4'b1000, 2, 1'b0};
    tbl[10] = '{4'b0000, NPIX,      1'b1, 1'b0, 4'b0000, 3, 1'b0};
    tbl[11] = '{4'b0010, NPIX - 1,  1'b1, 1'b0, 4'b0000, 1, 1'b1};
    tbl[12] = '{4'b0001, NPIX,      1'b1, 1'b1, 4'b0000, 0, 1'b0};
    tbl[13] = '{4'b0100, NPIX + 1,  1'b1, 1'b0, 4'b0000, 2, 1'b1};
    tbl[14] = '{4'b1000, 3,         1'b0, 1'b0, 4'b0000, 3, 1'b1};
    tbl[15] = '{4'b0001, NPIX,      1'b1, 1'b0, 4'b0000, 0, 1'b0};
    tbl[16] = '{4'b0011, NPIX,      1'b1, 1'b0, 4'b0001, 1, 1'b0};
    tbl[17] = '{4'b0001, NPIX - 1,  1'b1, 1'b1, 4'b0000, 0, 1'b1};

    bus.req = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_eng_rst", 64'(bus.eng_rst), 64'd0);

    for (int i = 0; i < 18; i++) begin
      run_job(tbl[i].or_mask, tbl[i].npix, tbl[i].done_en, tbl[i].same,
              tbl[i].mid, tbl[i].exp_g, tbl[i].exp_err);
    end

    // pixel strobe while idle must not be forwarded
    pix_seen = 0;
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_drop", 64'(pix_seen), 64'd0);
    chk("stray_busy", 64'(bus.busy), 64'd0);

    // reset in the middle of RUN, then the still-pending request restarts
    bus.req   = 4'b0100;
    e_npix    = NPIX;
    e_done_en = 1'b1;
    e_same    = 1'b0;
    exp_grant = 2;
    exp_idx   = 0;
    pix_seen  = 0;
    k = 0;
    while (pix_seen < 4 && k < 60) begin @(negedge clk); k++; end
    if (pix_seen < 4) begin chk("midrun_pixels", 64'(pix_seen), 64'd4); finish_now(); end
    chk("midrun_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_last = N_REQ - 1;
    chk("post_rst_eng_rst", 64'(bus.eng_rst), 64'd1);
    chk("post_rst_no_done", 64'(bus.req_done), 64'd0);
    run_job(4'b0000, NPIX, 1'b1, 1'b0, 4'b0000, rr_pick(model_last, bus.req), 1'b0);

    // randomized jobs against the round-robin model
    for (int t = 0; t < 40; t++) begin
      orm = N_REQ'($urandom);
      if ((bus.req | orm) == '0) orm = N_REQ'(1) << $urandom_range(N_REQ - 1);
      sel = $urandom_range(9);
      if (sel < 6)       np = NPIX;
      else if (sel == 6) np = NPIX - 1;
      else if (sel == 7) np = NPIX + 1;
      else               np = $urandom_range(NPIX);
      de = ($urandom_range(7) != 0);
      sm = 1'($urandom_range(1));
      mx = N_REQ'($urandom);
      g  = rr_pick(model_last, bus.req | orm);
      run_job(orm, np, de, sm, mx, g, (!de) || (np != NPIX));
    end

    bus.req = '0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/conv_engine_arbiter.md
Name: conv_engine_arbiter

Overview:
Shares a single convolution engine between N_REQ requesters, granting jobs round-robin. For each job it resets the engine, launches it and holds the operand-select index stable. It forwards output pixels tagged with requester ID and pixel index, and checks pixel count and timeout. It sits between the requester-side control logic and the convolution engine; an external mux driven by grant_id selects that requester's matrix/kernel onto the engine operands.

Parameters:
N_REQ, 4, number of requesters (>=2)
ACC_WIDTH, 32, engine output pixel width
HEIGHT, 4, input matrix rows (must match engine)
WIDTH, 4, input matrix columns (must match engine)
K, 2, kernel size (must match engine)
TIMEOUT, 1024, max cycles from launch to eng_done before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  N_REQ  per-requester job request, level, held until its req_done
req_done  out  N_REQ  one-cycle pulse, job finished for that requester
req_err  out  N_REQ  one-cycle pulse coincident with req_done on failed job
grant_id  out  $clog2(N_REQ)  operand-mux select, stable from CLEAR through RELEASE
busy  out  1  high while a job is in progress (state != IDLE)
eng_rst  out  1  engine reset
eng_start  out  1  engine start pulse
eng_done  in  1  engine done level
eng_out_valid  in  1  engine pixel strobe
eng_out_pixel  in  ACC_WIDTH  engine pixel
pix_valid  out  1  forwarded pixel strobe
pix_data  out  ACC_WIDTH  forwarded pixel
pix_id  out  $clog2(N_REQ)  owner of forwarded pixel
pix_idx  out  $clog2(OUT_H*OUT_W+1)  raster index of pixel within job, 0-based

Behaviour:
- Clock is clk. Reset is rst: synchronous and active-high. Everything samples on the rising edge of clk.
- Derived values: OUT_H = HEIGHT-K+1, OUT_W = WIDTH-K+1, NPIX = OUT_H*OUT_W.
- Reset values: state IDLE; eng_rst 1; eng_start 0; req_done/req_err 0; pix_valid 0; pix_data 0; pix_idx 0; grant_id 0; busy 0; RR pointer last = N_REQ-1; counters 0.
- Reset mid-job aborts silently, with no req_done. eng_rst stays 1 for the first cycle after rst falls.
- All outputs are registered.
- IDLE: eng_rst 0.
  - If any req bit is set, grant the first set bit searching last+1, last+2, ... (mod N_REQ). Load grant_id, update last, go to CLEAR.
  - If no req bit is set, stay in IDLE.
- CLEAR (1 cycle): eng_rst=1. This clears the engine's sticky FINISHED/done state. Go to LAUNCH.
- LAUNCH (1 cycle): eng_rst=0, eng_start=1. Clear pixel counter and timeout counter. Go to RUN.
- RUN:
  - Each cycle with eng_out_valid=1: next cycle pix_valid=1, pix_data=eng_out_pixel, pix_id=grant_id, pix_idx=count; then count+1.
  - Timeout counter increments every cycle.
  - On eng_done=1: go to RELEASE. Error if count != NPIX.
  - If the timeout counter reaches TIMEOUT-1 without eng_done: go to RELEASE with error; eng_rst=1 for that cycle.
  - eng_out_valid and eng_done in the same cycle: the pixel is still forwarded and counted before the check.
- RELEASE (1 cycle): req_done[grant_id]=1; req_err[grant_id]=error. Go to IDLE.
  - The requester drops req on seeing req_done. A req still high in IDLE the cycle after RELEASE is treated as a new job.
- Minimum idle-to-idle overhead is 4 cycles plus engine run time. With defaults the engine run is NPIX*(K*K+1)=45 cycles, with eng_done 1-2 cycles after the last pixel.
- req dropping mid-job is ignored: the job completes and req_done still pulses.
- A newly asserted req never preempts the current job.
- Pixels arriving outside RUN are dropped and not counted.
- count saturates at NPIX+1, so over-run is still flagged.
- grant_id never changes while busy=1.

Test Plan:
1. Single job: req=0001, engine model emits 9 pixels (defaults) then done → grant_id=0; eng_rst pulse then eng_start pulse on consecutive cycles; pix_idx 0..8 with pix_id=0; req_done=0001 with req_err=0; busy low afterwards.
2. Round-robin: req=1111 held, each requester dropping req on its done → grant order 0,1,2,3. Re-raise all bits → order 0,1,2,3 again. No requester is granted twice in a row while others wait.
3. Contention after grant: start with req=0100; raise req=1000 mid-job → job 2 finishes untouched, then grant 3. grant_id stays 2 throughout job 2.
4. Short job: engine asserts eng_done after only 8 pixels → req_done and req_err pulse together for that requester.
5. Timeout: TIMEOUT=64, engine never asserts done → at cycle 63 after LAUNCH, eng_rst=1, req_done and req_err pulse, return to IDLE. The next request proceeds normally.
6. Reset mid-RUN after 4 pixels → all outputs at reset values next cycle, no req_done, eng_rst=1. With req still high after rst falls, the job restarts from grant with pix_idx 0.
